cdb_arbiter: RTL

- Shares the single Common Data Bus (CDB) among the functional units that complete results: ALU, LD, FP1 and FP2.
- Each requester gets a one-entry holding register. A round-robin scheduler picks one held result per cycle and drives it onto a registered CDB.
- The CDB feeds tag wakeup in the reservation-station table and the map-table ready bits.
- Backpressure to each FU is a valid/ready handshake.

---
 rtl/cdb_arbiter_pkg.sv | 24 ++
 rtl/cdb_arbiter_if.sv | 24 ++
 rtl/cdb_arbiter_rr_pick.sv | 31 +++
 rtl/cdb_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter: requester indices, broadcast
// packet layout and the hardwired-zero tag that is never broadcast.
package cdb_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam logic [TAG_W-1:0] ZERO_TAG = '0;

  typedef enum logic [PTR_W-1:0] {
    CDB_ALU = 2'd0,
    CDB_LD  = 2'd1,
    CDB_FP1 = 2'd2,
    CDB_FP2 = 2'd3
  } cdb_req_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_packet_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake plus CDB broadcast, flush and perf counter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                            flush;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            cdb_valid;
  logic [TAG_W-1:0]                cdb_tag;
  logic [DATA_W-1:0]               cdb_data;
  logic [CNT_W-1:0]                conflict_cnt;

  modport master (
    output flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, conflict_cnt
  );

  modport slave (
    input  flush, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, conflict_cnt
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping, returned both one-hot and encoded.
module cdb_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_any
);
  logic [PTR_W-1:0] w_idx;

  // Scan farthest-first so the candidate closest to i_ptr is written last.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_any          = 1'b1;
        o_winner       = w_idx;
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per functional unit, round-robin
// selection of one held result per cycle onto a registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave cdb_bus
);
  logic [NUM_REQ-1:0]             r_hold_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  r_hold_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_hold_data;
  logic [PTR_W-1:0]               r_rr_ptr;
  cdb_packet_t                    r_cdb;
  logic [CNT_W-1:0]               r_conflict_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_accept;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_any;
  logic               w_multi;
  logic               w_bcast;

  cdb_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .i_req    (r_hold_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A slot being drained this cycle can refill at the same edge.
  assign w_ready    = (reset || cdb_bus.flush) ? '0 : (~r_hold_valid | w_grant);
  assign w_accept   = cdb_bus.req_valid & w_ready;
  assign w_multi    = $countones(r_hold_valid) >= 2;
  assign w_bcast    = w_any && (r_hold_tag[w_winner] != ZERO_TAG);
  assign w_next_ptr = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_valid   <= '0;
      r_hold_tag     <= '0;
      r_hold_data    <= '0;
      r_rr_ptr       <= '0;
      r_cdb          <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_multi && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      if (cdb_bus.flush) begin
        r_hold_valid <= '0;
        r_rr_ptr     <= '0;
        r_cdb.valid  <= 1'b0;
      end else begin
        // Zero-tag winners drain their slot but leave the bus idle.
        r_cdb.valid <= w_bcast;
        if (w_bcast) begin
          r_cdb.tag  <= r_hold_tag[w_winner];
          r_cdb.data <= r_hold_data[w_winner];
        end
        if (w_any)
          r_rr_ptr <= w_next_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w_accept[i]) begin
            r_hold_valid[i] <= 1'b1;
            r_hold_tag[i]   <= cdb_bus.req_tag[i];
            r_hold_data[i]  <= cdb_bus.req_data[i];
          end else if (w_grant[i]) begin
            r_hold_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign cdb_bus.req_ready    = w_ready;
  assign cdb_bus.cdb_valid    = r_cdb.valid;
  assign cdb_bus.cdb_tag      = r_cdb.tag;
  assign cdb_bus.cdb_data     = r_cdb.data;
  assign cdb_bus.conflict_cnt = r_conflict_cnt;
endmodule
